alu_op_seq: RTL and testbench

- Board-level operation sequencer that drives the team's 5-bit ALU from switches and buttons.
- Debounces buttons and captures operands and function in a small FSM.
- Holds the ALU inputs stable for one execute cycle, then registers result and flags for display.
- Supports chained operations (previous result becomes A) and keeps a running count of executed operations.

---
 rtl/alu_op_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_op_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_seq.sv
// Board-level sequencer for the 5-bit ALU: debounces buttons, captures operands and function
// from the switches, holds them for one execute cycle and registers the result for display.
module alu_op_seq #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [15:0] sw,
    output logic [4:0]  alu_a,
    output logic [4:0]  alu_b,
    output logic [2:0]  alu_func,
    input  logic [4:0]  alu_out,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    output logic        busy,
    output logic [15:0] ledr,
    output logic [3:0]  seg1,
    output logic [3:0]  seg2
);

    localparam int DBW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        GOT_A = 3'b001,
        EXEC  = 3'b010,
        SHOW  = 3'b011
    } state_t;

    state_t              state, state_next;
    logic [2:0][DBW-1:0] db_cnt;
    logic [2:0]          db_level, db_level_q, press;
    logic                clr_p, chn_p, nxt_p;
    logic                load_a, load_a_chain, load_bf, do_clear, do_exec;
    logic [4:0]          result;
    logic                flag_z, flag_o, flag_c;
    logic [CNT_W-1:0]    op_count;
    logic                unused_bits;

    assign unused_bits = ^{btn[4:3], sw[15:13]};

    // Saturating per-button counters; a press is the rising edge of the saturated level.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt     <= '0;
            db_level_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!btn[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] != DB_MAX)
                    db_cnt[i] <= db_cnt[i] + 1'b1;
            end
            db_level_q <= db_level;
        end
    end

    always_comb begin
        db_level = '0;
        for (int i = 0; i < 3; i++)
            db_level[i] = (db_cnt[i] == DB_MAX);
    end

    assign press = db_level & ~db_level_q;
    assign clr_p = press[2];
    assign chn_p = press[1] & ~press[2];
    assign nxt_p = press[0] & ~press[1] & ~press[2];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        load_a       = 1'b0;
        load_a_chain = 1'b0;
        load_bf      = 1'b0;
        do_clear     = 1'b0;
        do_exec      = 1'b0;
        case (state)
            IDLE: begin
                if (clr_p) begin
                    do_clear = 1'b1;
                end else if (nxt_p) begin
                    load_a     = 1'b1;
                    state_next = GOT_A;
                end
            end
            GOT_A: begin
                if (clr_p) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end else if (nxt_p) begin
                    load_bf    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                do_exec    = 1'b1;
                state_next = SHOW;
            end
            SHOW: begin
                if (clr_p) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end else if (chn_p) begin
                    load_a_chain = 1'b1;
                    load_bf      = 1'b1;
                    state_next   = EXEC;
                end else if (nxt_p) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands only move on capture edges, so the ALU sees stable inputs for the whole EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= '0;
            result   <= '0;
            flag_z   <= 1'b0;
            flag_o   <= 1'b0;
            flag_c   <= 1'b0;
            op_count <= '0;
        end else begin
            if (do_clear) begin
                alu_a    <= '0;
                alu_b    <= '0;
                alu_func <= '0;
                result   <= '0;
                flag_z   <= 1'b0;
                flag_o   <= 1'b0;
                flag_c   <= 1'b0;
            end
            if (load_a)
                alu_a <= sw[4:0];
            if (load_a_chain)
                alu_a <= result;
            if (load_bf) begin
                alu_b    <= sw[9:5];
                alu_func <= sw[12:10];
            end
            if (do_exec) begin
                result   <= alu_out;
                flag_z   <= alu_zero;
                flag_o   <= alu_overflow;
                flag_c   <= alu_carry;
                op_count <= op_count + 1'b1;
            end
        end
    end

    assign busy = (state == EXEC);
    assign ledr = {alu_a, state, flag_c, flag_o, flag_z, result};
    assign seg1 = result[3:0];
    assign seg2 = op_count[3:0];

endmodule

// File: tb/tb_alu_op_seq.sv
// Self-checking bench for alu_op_seq: a behavioural ALU closes the loop and a scoreboard
// queue holds the expected display contents for every operation the bench launches.
module tb_alu_op_seq;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  btn = '0;
    logic [15:0] sw = '0;
    logic [4:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_func;
    logic        alu_zero, alu_overflow, alu_carry, busy;
    logic [15:0] ledr;
    logic [3:0]  seg1, seg2;

    typedef struct packed {
        logic [4:0] a;
        logic [3:0] cnt;
        logic       c;
        logic       o;
        logic       z;
        logic [4:0] res;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    logic was_busy = 1'b0;

    alu_op_seq #(.DB_CYCLES(DB), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .busy(busy), .ledr(ledr), .seg1(seg1), .seg2(seg2)
    );

    always #5 clk = ~clk;

    // Reference 5-bit ALU, returns {carry, overflow, zero, result}.
    function automatic logic [7:0] alu_model(input logic [4:0] a, input logic [4:0] b, input logic [2:0] f);
        logic [5:0] s;
        logic [4:0] r;
        logic       c, o;
        c = 1'b0;
        o = 1'b0;
        r = '0;
        s = '0;
        case (f)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[4:0]; c = s[5]; o = (a[4] == b[4]) && (r[4] != a[4]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 6'd1; r = s[4:0]; c = s[5]; o = (a[4] != b[4]) && (r[4] != a[4]); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = {4'b0, (a < b)};
            default: r = {4'b0, (a == b)};
        endcase
        return {c, o, (r == 5'd0), r};
    endfunction

    always_comb {alu_carry, alu_overflow, alu_zero, alu_out} = alu_model(alu_a, alu_b, alu_func);

    // Scoreboard: the cycle after EXEC the display must show the oldest pending expectation.
    always @(negedge clk) begin
        if (was_busy && ledr[10:8] == 3'b011) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected ledr=%h required=no pending result", ledr);
            end else begin
                mon_e = sb.pop_front();
                if ({ledr, seg1, seg2} !== {mon_e.a, 3'b011, mon_e.c, mon_e.o, mon_e.z, mon_e.res, mon_e.res[3:0], mon_e.cnt}) begin
                    errors++;
                    $display("[TB] FAIL sb_result ledr=%h seg1=%h seg2=%h required ledr=%h seg1=%h seg2=%h", ledr, seg1, seg2,
                             {mon_e.a, 3'b011, mon_e.c, mon_e.o, mon_e.z, mon_e.res}, mon_e.res[3:0], mon_e.cnt);
                end
            end
        end
        was_busy = busy;
    end

    task automatic push_exp(input logic [4:0] a, input logic [4:0] b, input logic [2:0] f);
        exp_t       e;
        logic [7:0] m;
        m = alu_model(a, b, f);
        exp_count++;
        e.a   = a;
        e.cnt = 4'(exp_count);
        e.c   = m[7];
        e.o   = m[6];
        e.z   = m[5];
        e.res = m[4:0];
        sb.push_back(e);
    endtask

    task automatic set_sw(input logic [4:0] a, input logic [4:0] b, input logic [2:0] f);
        sw = {3'b000, f, b, a};
    endtask

    task automatic press(input int idx, input int hold, output int nbusy);
        nbusy = 0;
        btn[idx] = 1'b1;
        repeat (hold) begin @(negedge clk); if (busy) nbusy++; end
        btn[idx] = 1'b0;
        repeat (DB + 2) begin @(negedge clk); if (busy) nbusy++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 5'b00111;
        sw  = 16'hFFFF;
        repeat (8) @(negedge clk);
        checks++;
        if ({ledr, seg1, seg2, busy, alu_b, alu_func} !== 33'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold got=%h required=0", {ledr, seg1, seg2, busy, alu_b, alu_func});
        end
        btn = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (DB + 2) @(negedge clk);
        checks++;
        if ({ledr, seg1, seg2, busy} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL reset_release got=%h required=0", {ledr, seg1, seg2, busy});
        end
        exp_count = 0;
    endtask

    task automatic test_basic();
        int n;
        set_sw(5'd3, 5'd0, 3'd0);
        press(0, 10, n);
        checks++;
        if ({ledr[10:8], alu_a, n[3:0]} !== {3'b001, 5'd3, 4'd0}) begin
            errors++;
            $display("[TB] FAIL basic_got_a state=%0d a=%0d busy=%0d required state=1 a=3 busy=0", ledr[10:8], alu_a, n);
        end
        set_sw(5'd3, 5'd4, 3'd0);
        push_exp(5'd3, 5'd4, 3'd0);
        press(0, 10, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles got=%0d required=1", n);
        end
        checks++;
        if ({alu_a, alu_b, alu_func, ledr[10:8], ledr[5:0], seg2} !== {5'd3, 5'd4, 3'd0, 3'b011, 6'd7, 4'd1}) begin
            errors++;
            $display("[TB] FAIL basic_show a=%0d b=%0d f=%0d state=%0d res=%0d z=%b seg2=%0d required 3 4 0 3 7 0 1",
                     alu_a, alu_b, alu_func, ledr[10:8], ledr[4:0], ledr[5], seg2);
        end
    endtask

    task automatic test_chain();
        int n;
        set_sw(5'd0, 5'd7, 3'd1);
        push_exp(5'd7, 5'd7, 3'd1);
        press(1, 10, n);
        checks++;
        if ({n[3:0], alu_a, ledr[10:8], ledr[5:0], seg2} !== {4'd1, 5'd7, 3'b011, 6'b100000, 4'd2}) begin
            errors++;
            $display("[TB] FAIL chain busy=%0d a=%0d state=%0d res=%0d z=%b seg2=%0d required 1 7 3 0 1 2",
                     n, alu_a, ledr[10:8], ledr[4:0], ledr[5], seg2);
        end
    endtask

    task automatic test_glitch();
        int n;
        press(0, 10, n);
        checks++;
        if (ledr !== {5'd7, 3'b000, 8'hA0}) begin
            errors++;
            $display("[TB] FAIL show_to_idle_hold ledr=%h required=%h", ledr, {5'd7, 3'b000, 8'hA0});
        end
        set_sw(5'd9, 5'd0, 3'd0);
        repeat (5) begin
            btn[0] = 1'b1;
            repeat (DB - 1) @(negedge clk);
            btn[0] = 1'b0;
            repeat (2) @(negedge clk);
        end
        checks++;
        if ({ledr[10:8], alu_a} !== {3'b000, 5'd7}) begin
            errors++;
            $display("[TB] FAIL glitch state=%0d a=%0d required state=0 a=7", ledr[10:8], alu_a);
        end
        press(0, 50, n);
        checks++;
        if ({ledr[10:8], alu_a, n[3:0]} !== {3'b001, 5'd9, 4'd0}) begin
            errors++;
            $display("[TB] FAIL long_hold state=%0d a=%0d busy=%0d required state=1 a=9 busy=0", ledr[10:8], alu_a, n);
        end
        press(2, 10, n);
        checks++;
        if ({ledr[10:8], alu_a} !== {3'b000, 5'd0}) begin
            errors++;
            $display("[TB] FAIL clear state=%0d a=%0d required state=0 a=0", ledr[10:8], alu_a);
        end
        set_sw(5'd11, 5'd0, 3'd0);
        press(0, DB, n);
        checks++;
        if ({ledr[10:8], alu_a} !== {3'b001, 5'd11}) begin
            errors++;
            $display("[TB] FAIL exact_db_press state=%0d a=%0d required state=1 a=11", ledr[10:8], alu_a);
        end
    endtask

    task automatic test_priority();
        set_sw(5'd11, 5'd2, 3'd0);
        btn = 5'b00101;
        repeat (10) @(negedge clk);
        btn = '0;
        repeat (DB + 2) @(negedge clk);
        checks++;
        if ({ledr, seg2, busy} !== {16'h0000, 4'd2, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_over_next ledr=%h seg2=%0d busy=%b required ledr=0000 seg2=2 busy=0", ledr, seg2, busy);
        end
    endtask

    task automatic test_reset_in_exec();
        int n;
        bit found;
        set_sw(5'd5, 5'd6, 3'd0);
        press(0, 10, n);
        found = 1'b0;
        btn[0] = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (busy) begin
                found = 1'b1;
                rst = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL exec_timeout busy=%b required=1 within 20 cycles", busy);
        end
        @(negedge clk);
        btn = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ledr, seg1, seg2, alu_b} !== 29'd0) begin
            errors++;
            $display("[TB] FAIL reset_in_exec ledr=%h seg1=%0d seg2=%0d b=%0d required all 0", ledr, seg1, seg2, alu_b);
        end
        exp_count = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [4:0] a, b;
        for (int k = 0; k < 16; k++) begin
            a = 5'($urandom_range(0, 31));
            b = 5'($urandom_range(0, 31));
            set_sw(a, 5'd0, 3'd0);
            press(0, 6, n);
            set_sw(a, b, 3'd0);
            push_exp(a, b, 3'd0);
            press(0, 6, n);
            if (k == 14) begin
                checks++;
                if (seg2 !== 4'd15) begin
                    errors++;
                    $display("[TB] FAIL count_15 seg2=%0d required=15", seg2);
                end
            end
            press(0, 6, n);
        end
        checks++;
        if ({seg2, ledr[10:8]} !== {4'd0, 3'b000}) begin
            errors++;
            $display("[TB] FAIL count_wrap seg2=%0d state=%0d required seg2=0 state=0", seg2, ledr[10:8]);
        end
        set_sw(5'd16, 5'd0, 3'd0);
        press(0, 6, n);
        set_sw(5'd16, 5'd16, 3'd0);
        push_exp(5'd16, 5'd16, 3'd0);
        press(0, 6, n);
        checks++;
        if ({ledr[7:0], seg2} !== {8'hE0, 4'd1}) begin
            errors++;
            $display("[TB] FAIL add_16_16 flags_res=%h seg2=%0d required flags_res=e0 seg2=1", ledr[7:0], seg2);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_pending got=%0d required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_glitch();
        test_priority();
        test_reset_in_exec();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
